// File: rtl/core_boot_loader.sv
// core_boot_loader: boot sequencer upstream of core_flattened.
// Streams the data image into data memory, then INSTR, REG, BAR and PC
// packets into the core network port, then hands data memory to the core.
// Optional feature macro: BOOT_LOADER_DMEM_INIT_EN (enables the data-image
// store phase; when undefined the core owns data memory from reset).
// State is exported on state_o for monitoring.

package core_boot_loader_pkg;

  typedef enum logic [2:0] {
    NET_OP_NULL  = 3'd0,
    NET_OP_INSTR = 3'd1,
    NET_OP_REG   = 3'd2,
    NET_OP_PC    = 3'd3,
    NET_OP_BAR   = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [9:0]  net_id;
    net_op_e     net_op;
    logic [2:0]  reserved;
    logic [31:0] net_data;
    logic [9:0]  net_addr;
  } net_packet_s;

endpackage

module core_boot_loader
  import core_boot_loader_pkg::*;
#(
  parameter int          imem_words_p = 1024,
  parameter int          dmem_words_p = 1024,
  parameter int          reg_words_p  = 64,
  parameter logic [9:0]  net_ID_p     = 10'b1,
  parameter logic [31:0] bar_mask_p   = 32'h2,
  parameter logic [31:0] start_pc_p   = 32'h0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_i,
  output logic [9:0]                  instr_raddr_o,
  input  logic [15:0]                 instr_rdata_i,
  output logic [9:0]                  data_raddr_o,
  input  logic [31:0]                 data_rdata_i,
  output logic [5:0]                  reg_raddr_o,
  input  logic [39:0]                 reg_rdata_i,
  output logic                        mem_valid_o,
  output logic                        mem_wen_o,
  output logic [31:0]                 mem_addr_o,
  output logic [31:0]                 mem_wdata_o,
  input  logic                        mem_ready_i,
  output logic                        mem_select_o,
  output logic [$bits(net_packet_s)-1:0] net_packet_flat_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [2:0]                  state_o
);

  // Store handshake: mem_valid_o rises in DWR and holds address and data
  // stable until the cycle mem_ready_i is also high; that cycle is the
  // single transfer of the word and the index advances on its edge.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DRD  = 3'd1,
    DWR  = 3'd2,
    IRUN = 3'd3,
    RRUN = 3'd4,
    BAR  = 3'd5,
    PC   = 3'd6,
    DONE = 3'd7
  } state_e;

  // Index is one bit wider than any address port so terminal compares
  // never wrap; ports take the truncated low bits.
  localparam logic [10:0] imem_last_lp = 11'(imem_words_p - 1);
  localparam logic [10:0] reg_count_lp = 11'(reg_words_p);
`ifdef BOOT_LOADER_DMEM_INIT_EN
  localparam logic [10:0] dmem_last_lp = 11'(dmem_words_p - 1);
`endif

  state_e      state_q, state_d;
  logic [10:0] idx_q, idx_d;
  net_op_e     s1_op_q, s1_op_d;   // kind of ROM word arriving this cycle
  logic [9:0]  s1_addr_q;          // index of that ROM word
  net_packet_s pkt_q, pkt_d;

  // State, index, in-flight tag and output packet registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      s1_op_q   <= NET_OP_NULL;
      s1_addr_q <= '0;
      pkt_q     <= '{net_id: net_ID_p, net_op: NET_OP_NULL, reserved: 3'b0,
                     net_data: 32'b0, net_addr: 10'b0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      s1_op_q   <= s1_op_d;
      s1_addr_q <= idx_q[9:0];
      pkt_q     <= pkt_d;
    end
  end

  // Sequencing: next state, index, ROM addresses and the store port.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    s1_op_d       = NET_OP_NULL;
    instr_raddr_o = '0;
    data_raddr_o  = '0;
    reg_raddr_o   = '0;
    mem_valid_o   = 1'b0;
    mem_wen_o     = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          idx_d = '0;
`ifdef BOOT_LOADER_DMEM_INIT_EN
          state_d = DRD;
`else
          state_d = IRUN;
`endif
        end
      end
`ifdef BOOT_LOADER_DMEM_INIT_EN
      DRD: begin
        data_raddr_o = idx_q[9:0];
        state_d      = DWR;
      end
      DWR: begin
        // Address stays put, so the ROM output remains the captured word
        // for as long as the store is stalled.
        data_raddr_o = idx_q[9:0];
        mem_valid_o  = 1'b1;
        mem_wen_o    = 1'b1;
        mem_addr_o   = {19'd0, idx_q, 2'b00};
        mem_wdata_o  = data_rdata_i;
        if (mem_ready_i) begin
          if (idx_q == dmem_last_lp) begin
            idx_d   = '0;
            state_d = IRUN;
          end else begin
            idx_d   = idx_q + 11'd1;
            state_d = DRD;
          end
        end
      end
`endif
      IRUN: begin
        instr_raddr_o = idx_q[9:0];
        s1_op_d       = NET_OP_INSTR;
        if (idx_q == imem_last_lp) begin
          idx_d   = '0;
          state_d = RRUN;
        end else begin
          idx_d = idx_q + 11'd1;
        end
      end
      RRUN: begin
        // One extra cycle at idx == reg_words_p drains the last ROM read.
        if (idx_q == reg_count_lp) begin
          state_d = BAR;
        end else begin
          reg_raddr_o = idx_q[5:0];
          s1_op_d     = NET_OP_REG;
          idx_d       = idx_q + 11'd1;
        end
      end
      BAR:     state_d = PC;
      PC:      state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Packet build: ROM words one cycle after their address, BAR/PC direct.
  always_comb begin
    pkt_d = '{net_id: net_ID_p, net_op: NET_OP_NULL, reserved: 3'b0,
              net_data: 32'b0, net_addr: 10'b0};
    case (s1_op_q)
      NET_OP_INSTR: begin
        pkt_d.net_op   = NET_OP_INSTR;
        pkt_d.net_data = {16'b0, instr_rdata_i};
        pkt_d.net_addr = s1_addr_q;
      end
      NET_OP_REG: begin
        pkt_d.net_op   = NET_OP_REG;
        pkt_d.net_data = reg_rdata_i[31:0];
        pkt_d.net_addr = {4'b0, reg_rdata_i[37:32]};
      end
      default: ;
    endcase
    if (state_q == BAR) begin
      pkt_d.net_op   = NET_OP_BAR;
      pkt_d.net_data = bar_mask_p;
      pkt_d.net_addr = 10'd24;
    end else if (state_q == PC) begin
      pkt_d.net_op   = NET_OP_PC;
      pkt_d.net_data = start_pc_p;
      pkt_d.net_addr = 10'd0;
    end
  end

  assign net_packet_flat_o = pkt_q;
  assign busy_o            = (state_q != IDLE) && (state_q != DONE);
  assign done_o            = (state_q == DONE);
  assign state_o           = state_q;

`ifdef BOOT_LOADER_DMEM_INIT_EN
  assign mem_select_o = (state_q == DONE);
  logic unused_bits;
  assign unused_bits = ^reg_rdata_i[39:38];
`else
  assign mem_select_o = 1'b1;
  logic unused_bits;
  assign unused_bits = ^{reg_rdata_i[39:38], data_rdata_i, mem_ready_i,
                         32'(dmem_words_p)};
`endif

endmodule

// File: tb/tb_core_boot_loader.sv
// tb_core_boot_loader: randomized and directed boot runs of core_boot_loader
// against a reference list of expected stores and packets.
`timescale 1ns/1ps
module tb_core_boot_loader;
  import core_boot_loader_pkg::*;

  localparam int          imem_words_lp = 3;
  localparam int          dmem_words_lp = 4;
  localparam int          reg_words_lp  = 2;
  localparam logic [9:0]  net_id_lp     = 10'd1;
  localparam logic [31:0] bar_lp        = 32'h2;
  localparam logic [31:0] pc_lp         = 32'h0;
  localparam int          pw_lp         = $bits(net_packet_s);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              start_i = 1'b0;
  logic              mem_ready_i = 1'b1;
  logic [9:0]        instr_raddr_o, data_raddr_o;
  logic [5:0]        reg_raddr_o;
  logic [15:0]       instr_rdata_i = '0;
  logic [31:0]       data_rdata_i = '0;
  logic [39:0]       reg_rdata_i = '0;
  logic              mem_valid_o, mem_wen_o, mem_select_o, busy_o, done_o;
  logic [31:0]       mem_addr_o, mem_wdata_o;
  logic [pw_lp-1:0]  net_packet_flat_o;
  logic [2:0]        state_mon_unused;

  core_boot_loader #(
    .imem_words_p(imem_words_lp), .dmem_words_p(dmem_words_lp),
    .reg_words_p(reg_words_lp), .net_ID_p(net_id_lp),
    .bar_mask_p(bar_lp), .start_pc_p(pc_lp)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .instr_raddr_o(instr_raddr_o), .instr_rdata_i(instr_rdata_i),
    .data_raddr_o(data_raddr_o), .data_rdata_i(data_rdata_i),
    .reg_raddr_o(reg_raddr_o), .reg_rdata_i(reg_rdata_i),
    .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_select_o(mem_select_o),
    .net_packet_flat_o(net_packet_flat_o),
    .busy_o(busy_o), .done_o(done_o), .state_o(state_mon_unused)
  );

  // ---------------- image ROMs (1-cycle synchronous read) ----------------
  logic [15:0] instr_rom [1024];
  logic [31:0] data_rom  [1024];
  logic [39:0] reg_rom   [64];

  always @(posedge clk) begin
    instr_rdata_i <= instr_rom[instr_raddr_o];
    data_rdata_i  <= data_rom[data_raddr_o];
    reg_rdata_i   <= reg_rom[reg_raddr_o];
  end

`ifdef BOOT_LOADER_DMEM_INIT_EN
  localparam logic rst_sel_lp = 1'b0;
`else
  localparam logic rst_sel_lp = 1'b1;
`endif

  // ---------------- scoreboard ----------------
  logic [pw_lp-1:0] exp_q[$];
  logic [63:0]      st_exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [pw_lp-1:0] mk_pkt(input net_op_e op,
                                              input logic [31:0] d,
                                              input logic [9:0] a);
    net_packet_s p;
    p.net_id   = net_id_lp;
    p.net_op   = op;
    p.reserved = 3'b0;
    p.net_data = d;
    p.net_addr = a;
    return p;
  endfunction

  // Reference sequence straight from the boot order rules.
  task automatic build_model();
    exp_q.delete();
    st_exp_q.delete();
    for (int i = 0; i < imem_words_lp; i++)
      exp_q.push_back(mk_pkt(NET_OP_INSTR, {16'h0, instr_rom[i]}, 10'(i)));
    for (int i = 0; i < reg_words_lp; i++)
      exp_q.push_back(mk_pkt(NET_OP_REG, reg_rom[i][31:0],
                             {4'b0, reg_rom[i][37:32]}));
    exp_q.push_back(mk_pkt(NET_OP_BAR, bar_lp, 10'd24));
    exp_q.push_back(mk_pkt(NET_OP_PC, pc_lp, 10'd0));
`ifdef BOOT_LOADER_DMEM_INIT_EN
    for (int i = 0; i < dmem_words_lp; i++)
      st_exp_q.push_back({32'(i * 4), data_rom[i]});
`endif
  endtask

  // ---------------- driver: one boot run ----------------
  task automatic do_boot(input bit directed, input bit abort_in_irun);
    int cyc, hold, pkts, gaps, first_cyc, post, st_idx, last_acc;
    bit pc_seen, prev_null, aborted;
    net_packet_s obs;
    logic [63:0] got_st;

    cyc = 0; hold = 0; pkts = 0; gaps = 0; first_cyc = 0; post = 0;
    st_idx = 0; last_acc = 0; pc_seen = 0; prev_null = 0; aborted = 0;

    @(negedge clk);
    reset = 1'b0; start_i = 1'b0; mem_ready_i = 1'b1;
    #1;
    check_eq("rst_pkt", net_packet_flat_o, mk_pkt(NET_OP_NULL, 32'h0, 10'h0));
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_done", done_o, 1'b0);
    check_eq("rst_sel", mem_select_o, rst_sel_lp);
    check_eq("rst_mem", {mem_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o}, '0);
    check_eq("rst_addr", {instr_raddr_o, data_raddr_o, reg_raddr_o}, '0);
    @(negedge clk);
    reset = 1'b1;
    build_model();
    start_i = 1'b1;

    while (!(pc_seen && post >= 6) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start_i = 1'b0;
      obs = net_packet_s'(net_packet_flat_o);

      if (abort_in_irun && instr_raddr_o == 10'd1) begin
        reset = 1'b0;
        #1;
        check_eq("abort_pkt", net_packet_flat_o, mk_pkt(NET_OP_NULL, 32'h0, 10'h0));
        check_eq("abort_busy", busy_o, 1'b0);
        check_eq("abort_sel", mem_select_o, rst_sel_lp);
        aborted = 1;
        @(negedge clk);
        reset = 1'b1;
        break;
      end

      if (obs.net_op != NET_OP_NULL) begin
        if (pkts == 0) first_cyc = cyc;
        if (prev_null && pkts > 0) gaps++;
        if (exp_q.size() == 0)
          check_eq("pkt_extra", net_packet_flat_o, mk_pkt(NET_OP_NULL, 32'h0, 10'h0));
        else
          check_eq("pkt", net_packet_flat_o, exp_q.pop_front());
        pkts++;
        prev_null = 0;
        if (obs.net_op == NET_OP_PC) begin
          pc_seen = 1;
          check_eq("pc_sel", mem_select_o, 1'b1);
        end
      end else begin
        prev_null = 1;
        if (pc_seen)
          check_eq("null_tail", net_packet_flat_o, mk_pkt(NET_OP_NULL, 32'h0, 10'h0));
      end
      check_eq("busy", busy_o, !pc_seen);
      check_eq("done", done_o, pc_seen);

`ifdef BOOT_LOADER_DMEM_INIT_EN
      if (directed) begin
        mem_ready_i = 1'b1;
        if (mem_valid_o && mem_addr_o == 32'd8 && hold < 5) begin
          mem_ready_i = 1'b0;
          hold++;
          check_eq("stall_hold", {mem_addr_o, mem_wdata_o}, {32'd8, data_rom[2]});
        end
      end else begin
        mem_ready_i = ($urandom_range(0, 2) != 0);
      end
      if (mem_valid_o) check_eq("st_wen", mem_wen_o, 1'b1);
      if (!pc_seen) check_eq("sel_low", mem_select_o, 1'b0);
      if (mem_valid_o && mem_ready_i) begin
        got_st = {mem_addr_o, mem_wdata_o};
        if (st_exp_q.size() == 0) check_eq("st_extra", got_st, '0);
        else check_eq("store", got_st, st_exp_q.pop_front());
        if (directed)
          check_eq("st_spacing", 64'(cyc - last_acc), (st_idx == 2) ? 64'd7 : 64'd2);
        last_acc = cyc;
        st_idx++;
      end
`else
      mem_ready_i = ($urandom_range(0, 1) != 0);
      check_eq("no_store", {mem_valid_o, mem_wen_o}, 2'b00);
      check_eq("sel_core", mem_select_o, 1'b1);
`endif

      if (pc_seen) begin
        post++;
        if (post == 2) start_i = 1'b1;
        if (post == 3) start_i = 1'b0;
      end
    end

    if (abort_in_irun) begin
      check_eq("abort_hit", aborted, 1'b1);
    end else begin
      check_eq("timeout", pc_seen, 1'b1);
      check_eq("pkt_left", 64'(exp_q.size()), 64'd0);
      check_eq("st_left", 64'(st_exp_q.size()), 64'd0);
      check_eq("gap", 64'(gaps), 64'd0);
`ifndef BOOT_LOADER_DMEM_INIT_EN
      check_eq("first_lat", 64'(first_cyc), 64'd3);
`endif
    end
    start_i = 1'b0;
  endtask

  task automatic randomize_roms();
    for (int i = 0; i < imem_words_lp; i++) instr_rom[i] = 16'($urandom);
    for (int i = 0; i < dmem_words_lp; i++) data_rom[i] = $urandom;
    for (int i = 0; i < reg_words_lp; i++)
      reg_rom[i] = {2'($urandom), 6'($urandom_range(0, 63)), 32'($urandom)};
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    for (int i = 0; i < 1024; i++) begin
      instr_rom[i] = '0;
      data_rom[i]  = '0;
    end
    for (int i = 0; i < 64; i++) reg_rom[i] = '0;
    instr_rom[0] = 16'hA001; instr_rom[1] = 16'hA002; instr_rom[2] = 16'hA003;
    data_rom[0] = 32'd11; data_rom[1] = 32'd22; data_rom[2] = 32'd33; data_rom[3] = 32'd44;
    reg_rom[0] = 40'h05_DEADBEEF;
    reg_rom[1] = 40'h3F_00000001;

    repeat (2) @(negedge clk);
    do_boot(1'b1, 1'b0);
    do_boot(1'b0, 1'b1);
    do_boot(1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      randomize_roms();
      do_boot(1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
